// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : FFT core constants, sequencer state encoding, 6-bit bit-reverse.
// Rev 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

   localparam int N_POINTS = 64;
   localparam int LOG2N    = 6;
   localparam int N_BF     = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      DRAIN   = 3'd3,
      UNLOAD  = 3'd4
   } state_t;

   function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] idx);
      logic [LOG2N-1:0] rev;
      for (int i = 0; i < LOG2N; i++) begin
         rev[i] = idx[LOG2N-1-i];
      end
      return rev;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fft_twiddle_addr_gen.sv
// ============================================================================
// fft_twiddle_addr_gen : (stage, bf_idx) -> twiddle ROM address, combinational.
// Rev 1.0
// ============================================================================
`default_nettype none

module fft_twiddle_addr_gen
   import fft_pkg::*;
#(
   parameter int BF_W = LOG2N - 1
)(
   input  logic [2:0]      stage,
   input  logic [BF_W-1:0] bf_idx,
   output logic [BF_W-1:0] tw_addr
);

   logic [BF_W-1:0] span_mask;

   // bf_idx mod (N/2 >> stage) is a mask because the span is a power of two.
   always_comb begin
      span_mask = {BF_W{1'b1}} >> stage;
      tw_addr   = (bf_idx & span_mask) << stage;
   end

endmodule

`default_nettype wire

// File: rtl/fft_sequencer.sv
// ============================================================================
// fft_sequencer : load / compute / drain / bit-reversed unload control FSM.
// Rev 1.0   Optional macro FFT_SEQ_ABORT_EN adds the abort input.
// ============================================================================
`default_nettype none

module fft_sequencer
   import fft_pkg::*;
#(
   parameter int LOG2N      = 6,
   parameter int BF_LATENCY = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din_valid,
`ifdef FFT_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             load_we,
   output logic [LOG2N-1:0] load_addr,
   output logic             bf_en,
   output logic [2:0]       stage,
   output logic [LOG2N-2:0] bf_idx,
   output logic [LOG2N-2:0] tw_addr,
   output logic             bank_sel,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr,
   output logic             dataind,
   output logic             busy,
   output logic             done
);

   localparam logic [LOG2N-1:0] LAST_SAMPLE = '1;
   localparam logic [LOG2N-2:0] LAST_BF     = '1;
   localparam logic [2:0]       LAST_STAGE  = 3'(LOG2N - 1);
   localparam logic [2:0]       LAST_DRAIN  = 3'(BF_LATENCY - 1);

   state_t           state, state_nx;
   logic [LOG2N-1:0] load_cnt, load_cnt_nx;
   logic [LOG2N-1:0] unload_cnt, unload_cnt_nx;
   logic [2:0]       drain_cnt, drain_cnt_nx;
   logic [2:0]       stage_nx;
   logic [LOG2N-2:0] bf_idx_nx, tw_addr_nx;
   logic             bank_nx, dataind_nx, done_nx;
   logic             abort_req;

`ifdef FFT_SEQ_ABORT_EN
   assign abort_req = abort & (state != IDLE);
`else
   assign abort_req = 1'b0;
`endif

   // The write strobe follows din_valid in the same cycle so it stays paired with its sample.
   assign load_we   = din_valid & (state == LOAD) & ~abort_req;
   assign load_addr = load_cnt;

   fft_twiddle_addr_gen #(.BF_W(LOG2N - 1)) u_tw_gen (
      .stage   (stage_nx),
      .bf_idx  (bf_idx_nx),
      .tw_addr (tw_addr_nx)
   );

   always_comb begin
      state_nx      = state;
      load_cnt_nx   = load_cnt;
      unload_cnt_nx = unload_cnt;
      drain_cnt_nx  = drain_cnt;
      stage_nx      = stage;
      bf_idx_nx     = bf_idx;
      bank_nx       = bank_sel;
      dataind_nx    = 1'b0;
      done_nx       = 1'b0;
      if (abort_req) begin
         state_nx      = IDLE;
         load_cnt_nx   = '0;
         unload_cnt_nx = '0;
         drain_cnt_nx  = '0;
         stage_nx      = '0;
         bf_idx_nx     = '0;
         bank_nx       = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nx    = LOAD;
                  load_cnt_nx = '0;
               end
            end
            LOAD: begin
               if (din_valid) begin
                  if (load_cnt == LAST_SAMPLE) begin
                     state_nx    = COMPUTE;
                     load_cnt_nx = '0;
                     stage_nx    = '0;
                     bf_idx_nx   = '0;
                     bank_nx     = ~bank_sel;
                  end else begin
                     load_cnt_nx = load_cnt + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (bf_idx == LAST_BF) begin
                  state_nx     = DRAIN;
                  bf_idx_nx    = '0;
                  drain_cnt_nx = '0;
               end else begin
                  bf_idx_nx = bf_idx + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == LAST_DRAIN) begin
                  bank_nx      = ~bank_sel;
                  drain_cnt_nx = '0;
                  if (stage == LAST_STAGE) begin
                     state_nx      = UNLOAD;
                     unload_cnt_nx = '0;
                     dataind_nx    = 1'b1;
                  end else begin
                     state_nx = COMPUTE;
                     stage_nx = stage + 3'd1;
                  end
               end else begin
                  drain_cnt_nx = drain_cnt + 3'd1;
               end
            end
            UNLOAD: begin
               if (unload_cnt == LAST_SAMPLE) begin
                  state_nx      = IDLE;
                  unload_cnt_nx = '0;
                  stage_nx      = '0;
                  done_nx       = 1'b1;
               end else begin
                  unload_cnt_nx = unload_cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         load_cnt   <= '0;
         unload_cnt <= '0;
         drain_cnt  <= '0;
         stage      <= '0;
         bf_idx     <= '0;
         tw_addr    <= '0;
         bank_sel   <= 1'b0;
         bf_en      <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         dataind    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         load_cnt   <= load_cnt_nx;
         unload_cnt <= unload_cnt_nx;
         drain_cnt  <= drain_cnt_nx;
         stage      <= stage_nx;
         bf_idx     <= bf_idx_nx;
         tw_addr    <= tw_addr_nx;
         bank_sel   <= bank_nx;
         bf_en      <= (state_nx == COMPUTE);
         rd_en      <= (state_nx == UNLOAD);
         rd_addr    <= bit_reverse(unload_cnt_nx);
         dataind    <= dataind_nx;
         busy       <= (state_nx != IDLE);
         done       <= done_nx;
      end
   end

endmodule

`default_nettype wire

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Top-level control FSM for the 64-point radix-2 DIF FFT core. Sequences input loading into the ping-pong sample RAM, issues 6 stages × 32 butterfly operations with twiddle addresses, then unloads in bit-reversed order. Provides the dataind pulse that starts output_counter. Sits between the input interface, the butterfly/twiddle datapath and the output stage.

Parameters:
LOG2N, 6, log2 of FFT size; N = 2^LOG2N = 64 points, N/2 = 32 butterflies per stage.
BF_LATENCY, 2, butterfly pipeline depth in cycles (issue to RAM writeback); legal range 1..7.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
start  in  1  begin a new transform; sampled only in IDLE.
din_valid  in  1  input sample present this cycle; LOAD stalls while low.
load_we  out  1  sample RAM write enable, equals din_valid while in LOAD.
load_addr  out  LOG2N  natural-order write address.
bf_en  out  1  issue one butterfly this cycle.
stage  out  3  current stage, 0..LOG2N-1.
bf_idx  out  LOG2N-1  butterfly index within stage, 0..31.
tw_addr  out  LOG2N-1  twiddle ROM address.
bank_sel  out  1  ping-pong read bank; write bank = ~bank_sel.
rd_en  out  1  unload read enable.
rd_addr  out  LOG2N  bit-reversed unload address.
dataind  out  1  one-cycle pulse to output_counter.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse on UNLOAD -> IDLE.

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; bank_sel 0; every output 0.
- All outputs registered; state changes on rising clk.
- IDLE: start=1 -> LOAD next cycle, load counter cleared. start while busy is ignored.
- LOAD: each din_valid=1 cycle: load_we=1, load_addr=count, count++. din_valid=0 -> hold, load_we=0. After the write at addr 63 -> COMPUTE, stage=0, bf_idx=0. Writes land in bank ~bank_sel. bank_sel toggles on LOAD exit so stage 0 reads the loaded bank.
- COMPUTE: bf_en=1 for 32 consecutive cycles, bf_idx 0..31.
  - span = 32 >> stage; tw_addr = (bf_idx mod span) << stage, truncated to 5 bits.
  - After bf_idx=31 -> DRAIN.
- DRAIN: bf_en=0 for exactly BF_LATENCY cycles.
  - Exit when stage < 5: bank_sel toggles, stage++, bf_idx=0, back to COMPUTE.
  - Exit when stage = 5: bank_sel toggles, go to UNLOAD.
  - Cost: 32+BF_LATENCY cycles per stage; 204 total for BF_LATENCY=2.
- UNLOAD: 64 cycles, rd_en=1, rd_addr = bit-reverse(unload count 0..63).
  - dataind=1 only in the first UNLOAD cycle.
  - After count 63: done=1 for one cycle, state IDLE, rd_en=0.
- Counter wrap: load, bf_idx and unload counters are 6/5/6 bits. Terminal compares are exact; no counter wraps inside a state.
- start held high: a new transform starts only after done, on the first IDLE cycle.
- Reset mid-operation: immediate return to IDLE, no done pulse, no dataind.

Optional Feature:
FFT_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit). abort=1 in any non-IDLE state -> IDLE next cycle. All enables are deasserted that cycle. bank_sel returns to 0. No done, no dataind. abort in IDLE has no effect. abort has priority over all other transitions.
- Undefined: no port; the FSM always completes the transform.

Decomposition:
- Shared package fft_pkg:
  - state encoding constants: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
  - N_POINTS=64, LOG2N=6, N_BF=32.
  - bit-reverse function for 6-bit indices.
- One sub-module: fft_twiddle_addr_gen, combinational (stage, bf_idx) -> tw_addr, reused by the datapath testbench.

Test Plan:
- Reset then start, 64 back-to-back din_valid: load_addr 0..63; busy rises the cycle after start; 204 COMPUTE+DRAIN cycles; 64 UNLOAD cycles; rd_addr sequence 0,32,16,48,...,63; dataind once; done at cycle 1+64+204+64.
- din_valid toggled 1/0 during LOAD: load_addr advances only on valid cycles; LOAD lasts 128 cycles; total latency grows by 64.
- Twiddle check: stage 0 tw_addr = bf_idx; stage 1 tw = (bf_idx mod 16)<<1; stage 5 tw_addr = 0 for all 32 butterflies; bank_sel toggles 7 times per transform.
- BF_LATENCY=5: each DRAIN exactly 5 cycles with bf_en=0; compute phase lasts 222 cycles.
- rst low asynchronously mid-COMPUTE (stage 3, bf_idx 10): outputs 0 without a clock edge; no done; next start runs a clean transform.
- FFT_SEQ_ABORT_EN: abort during UNLOAD at count 20 -> IDLE next cycle, rd_en=0, no done; start accepted the following cycle.
